// File: rtl/param_data_ram.sv
// Word-addressed 32-bit RAM on a waitrequest bus. The first INIT_WORDS words are preloaded with a byte-reversed arithmetic series.
// Define PARAM_DATA_RAM_WAIT_EN to add WAIT_CYCLES wait states and input-hold checking. Without it, every access completes in one cycle.
module param_data_ram #(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_CYCLES = 2,
  parameter int          INIT_WORDS  = 30,
  parameter logic [31:0] INIT_BASE   = 32'h12345678,
  parameter logic [31:0] INIT_STEP   = 32'hDCBA1234
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic        data_waitrequest,
  output logic [31:0] data_readdata,
  output logic        protocol_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  function automatic logic [31:0] init_word(input int idx);
    logic [31:0] v;
    v = INIT_BASE + INIT_STEP * 32'(idx);
    if (idx >= INIT_WORDS) v = '0;
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  logic          request;
  logic          complete;
  logic          addr_ok;
  logic          wr_en;
  logic          held_change;
  logic          err_now;
  logic          protocol_err_q;
  logic [AW-1:0] word_idx;
  logic [31:0]   words [DEPTH_WORDS];

  assign request  = data_read | data_write;
  assign addr_ok  = (data_address[1:0] == 2'b00) &&
                    ({2'b00, data_address[31:2]} < 32'(DEPTH_WORDS));
  assign word_idx = data_address[AW+1:2];

`ifdef PARAM_DATA_RAM_WAIT_EN
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wait_q;
  logic [31:0] addr_q, wdat_q;
  logic        wr_q, rd_q;
  logic [3:0]  be_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Completion, abort and idle all fall back to cnt=0.
  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    if (request && data_waitrequest) begin
      state_d = WAIT;
      cnt_d   = cnt_q + 4'd1;
    end
  end

  always_comb begin
    data_waitrequest = request &&
                       ((state_q == IDLE) ? (WAIT_LIM != 4'd0) : (cnt_q < WAIT_LIM));
    complete         = request && !data_waitrequest;
  end

  // Snapshot of the inputs presented while stalled; the master must hold them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= 1'b0;
      addr_q <= '0;
      wdat_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      be_q   <= '0;
    end else begin
      wait_q <= data_waitrequest;
      addr_q <= data_address;
      wdat_q <= data_writedata;
      wr_q   <= data_write;
      rd_q   <= data_read;
      be_q   <= data_byteenable;
    end
  end

  // A dropped request is a legal abort, not a hold violation.
  assign held_change = wait_q && request &&
                       ({data_address, data_writedata, data_write, data_read, data_byteenable} !=
                        {addr_q, wdat_q, wr_q, rd_q, be_q});
`else
  assign data_waitrequest = 1'b0;
  assign complete         = request;
  assign held_change      = 1'b0;
`endif

  assign err_now = held_change || (complete && ((data_read && data_write) || !addr_ok));
  assign wr_en   = complete && data_write && !data_read && addr_ok;

  assign data_readdata = (complete && data_read && !data_write && addr_ok) ? words[word_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       protocol_err_q <= 1'b0;
    else if (err_now) protocol_err_q <= 1'b1;
  end
  assign protocol_err = protocol_err_q;

  // Storage is not reset; contents come only from the power-up initialiser and writes.
  for (genvar i = 0; i < DEPTH_WORDS; i++) begin : g_word
    logic [31:0] word_q = init_word(i);
    always_ff @(posedge clk) begin
      if (wr_en && (word_idx == AW'(i))) begin
        for (int b = 0; b < 4; b++) begin
          if (data_byteenable[b]) word_q[8*b +: 8] <= data_writedata[8*b +: 8];
        end
      end
    end
    assign words[i] = word_q;
  end

endmodule

// File: tb/tb_param_data_ram.sv
// Directed bench for param_data_ram: a vector table of back-to-back accesses, then sequences for abort, reset and error cases.
module tb_param_data_ram;

`ifdef PARAM_DATA_RAM_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic        data_waitrequest;
  logic [31:0] data_readdata;
  logic        protocol_err;

  int n_checks = 0;
  int n_pass   = 0;

  param_data_ram dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_address     (data_address),
    .data_write       (data_write),
    .data_read        (data_read),
    .data_writedata   (data_writedata),
    .data_byteenable  (data_byteenable),
    .data_waitrequest (data_waitrequest),
    .data_readdata    (data_readdata),
    .protocol_err     (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic        rd;
    logic [31:0] wdat;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic r,
                       input logic [31:0] wd, input logic [3:0] be);
    data_address    = a;
    data_write      = w;
    data_read       = r;
    data_writedata  = wd;
    data_byteenable = be;
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  // Present one access, wait for completion, and check the read data and stall count.
  task automatic access(input string nm, input logic [31:0] a, input logic w, input logic r,
                        input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
    int waits;
    waits = 0;
    drive(a, w, r, wd, be);
    @(negedge clk);
    while (data_waitrequest && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    check({nm, " rdata"}, data_readdata, exp);
    check({nm, " waits"}, 32'(waits), 32'(W));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input string nm);
    rst_n = 1'b0;
    #2;
    check({nm, " err cleared"}, 32'(protocol_err), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0000, 1'b0, 1'b1, 32'h0,         4'h0, 32'h7856_3412};
    vecs[1]  = '{32'h0000_0004, 1'b0, 1'b1, 32'h0,         4'h0, 32'hAC68_EEEE};
    vecs[2]  = '{32'h0000_0008, 1'b0, 1'b1, 32'h0,         4'h0, 32'hE07A_A8CB};
    vecs[3]  = '{32'h0000_0074, 1'b0, 1'b1, 32'h0,         4'h0, 32'h5C66_4813};
    vecs[4]  = '{32'h0000_0078, 1'b0, 1'b1, 32'h0,         4'h0, 32'h0000_0000};
    vecs[5]  = '{32'h0000_0010, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'h5, 32'h0000_0000};
    vecs[6]  = '{32'h0000_0010, 1'b0, 1'b1, 32'h0,         4'h0, 32'h48AD_1CEF};
    vecs[7]  = '{32'h0000_0014, 1'b1, 1'b0, 32'h1122_3344, 4'h0, 32'h0000_0000};
    vecs[8]  = '{32'h0000_0014, 1'b0, 1'b1, 32'h0,         4'h0, 32'h7CB1_D661};
    vecs[9]  = '{32'h0000_3FFC, 1'b1, 1'b0, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000};
    vecs[10] = '{32'h0000_3FFC, 1'b0, 1'b1, 32'h0,         4'h0, 32'hA5A5_A5A5};
    vecs[11] = '{32'h0000_000C, 1'b0, 1'b1, 32'h0,         4'h0, 32'h148D_62A8};

    rst_n = 1'b0;
    idle();
    #3;
    check("reset waitrequest", 32'(data_waitrequest), 32'd0);
    check("reset readdata",    data_readdata,         32'h0);
    check("reset err",         32'(protocol_err),     32'd0);
    data_read = 1'b1;
    #1;
    check("reset req waitrequest", 32'(data_waitrequest), 32'(W > 0));
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back accesses with no idle cycle in between.
    for (int i = 0; i < 12; i++) begin
      access($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].rd,
             vecs[i].wdat, vecs[i].be, vecs[i].exp);
      check($sformatf("vec%0d err", i), 32'(protocol_err), 32'd0);
    end
    idle();
    @(posedge clk);
    #1;

    // Aborted read at 0x8, then a full read at 0xC.
    drive(32'h8, 1'b0, 1'b1, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    idle();
    @(posedge clk);
    #1;
    access("abort retry", 32'hC, 1'b0, 1'b1, 32'h0, 4'h0, 32'h148D_62A8);
    idle();
    check("abort err", 32'(protocol_err), 32'd0);

    access("misaligned", 32'h3, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
    idle();
    check("misaligned err", 32'(protocol_err), 32'd1);
    reset_pulse("misaligned");

    access("range read", 32'h4000, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
    idle();
    check("range read err", 32'(protocol_err), 32'd1);
    reset_pulse("range read");

    access("range write", 32'h4000, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'h0);
    idle();
    check("range write err", 32'(protocol_err), 32'd1);
    reset_pulse("range write");
    access("word0 after range write", 32'h0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h7856_3412);
    access("word4095 after range write", 32'h3FFC, 1'b0, 1'b1, 32'h0, 4'h0, 32'hA5A5_A5A5);

    access("rd+wr", 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0);
    idle();
    check("rd+wr err", 32'(protocol_err), 32'd1);
    reset_pulse("rd+wr");
    access("word0 after rd+wr", 32'h0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h7856_3412);
    idle();

`ifdef PARAM_DATA_RAM_WAIT_EN
    // Address moves while stalled.
    drive(32'h4, 1'b0, 1'b1, 32'h0, 4'h0);
    @(negedge clk);
    check("hold stalled", 32'(data_waitrequest), 32'd1);
    @(posedge clk);
    #1;
    data_address = 32'h8;
    @(posedge clk);
    #1;
    check("hold err set", 32'(protocol_err), 32'd1);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("hold err sticky", 32'(protocol_err), 32'd1);
    reset_pulse("hold");

    // Reset during a stalled write must discard it.
    drive(32'h18, 1'b1, 1'b0, 32'h0BAD_F00D, 4'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    access("write aborted by reset", 32'h18, 1'b0, 1'b1, 32'h0, 4'h0, 32'hB0C3_903E);
    idle();
    check("reset abort err", 32'(protocol_err), 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
